microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Next-state address logic and state register for the microprogrammed control unit.
- Holds the current control state, which drives the microstore ROM address.
- Each cycle it picks the next state from the ROM's next-state control fields, the instruction encoder's state, the incremented state, or a one-level return register.
- Sits directly downstream of the microstore ROM and closes the ROM-to-state feedback loop. Also counts MOC wait cycles for timeout detection.

Parameters:
- RESET_STATE, 7'd0, state loaded on reset.
- FETCH_STATE, 7'd1, state forced when the instruction condition fails on COND_ENCODE.
- TIMEOUT, 8'd32, consecutive COND_INC stall cycles before timeout asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enc_state  in  7  decode target state from the instruction encoder.
- ns  in  3  ROM next-state control code.
- cr  in  7  ROM jump-address field.
- inv  in  1  ROM condition inverter.
- s  in  2  ROM condition select.
- moc  in  1  memory operation complete.
- cond  in  1  instruction condition-code check passed.
- state  out  7  current control state, registered, feeds the ROM address.
- ret_addr  out  7  return register contents.
- timeout  out  1  memory wait exceeded TIMEOUT, registered, sticky.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - state=RESET_STATE, ret_addr=0, wait counter=0, timeout=0.
- Condition test t = sel(s) XOR inv, where sel: 00 moc, 01 cond, 10 1'b1, 11 1'b0.
- inc = state+1, 7-bit; 127 wraps to 0, with no flag.
- Next state, registered on the rising clk edge:
  - 000 ENCODE: enc_state.
  - 001 RETURN: ret_addr.
  - 010 JUMP: cr.
  - 011 INC: inc.
  - 100 COND_JUMP: t ? cr : inc.
  - 101 COND_INC: t ? inc : state (hold/stall).
  - 110 COND_ENCODE: t ? enc_state : FETCH_STATE.
  - 111 CALL: next=cr and ret_addr<=inc on the same edge.
- ret_addr changes only on CALL. A CALL issued from the return target overwrites it (single level, no stack).
- Latency: inputs sampled at edge N appear on state after edge N. No combinational path from any input to any output.
- Wait counter:
  - Increments on each edge where ns=101 and t=0; saturates at 255.
  - Clears on any edge where the stall does not occur.
  - timeout<=1 on the edge the counter reaches TIMEOUT.
  - timeout stays 1 until reset.
  - timeout does not alter sequencing.
- X or undefined on ns is not handled; the ROM guarantees valid codes.

Test Plan:
- Reset mid-run: state=7'd45, assert reset between edges -> state=0, ret_addr=0, timeout=0 immediately, without waiting for a clock edge.
- Fetch/decode: from 0, ns=011 -> state 1. Then ns=000 with enc_state=7'd10 -> state 10. Then ns=011 at state 127 -> state 0 (wrap).
- Conditional jump: state=5, cr=7'd20, ns=100, s=00.
  - moc=1, inv=0 -> 20.
  - moc=1, inv=1 -> 6.
  - s=10, inv=0 -> 20 regardless of moc.
- Memory wait: ns=101, s=00, moc=0 -> state held.
  - moc=0 for 31 cycles -> timeout=0.
  - 32nd stall edge -> timeout=1.
  - moc=1 -> state+1, timeout still 1, counter 0.
- Condition skip: ns=110, s=01. cond=0 -> state=FETCH_STATE (1). cond=1, enc_state=7'd12 -> 12.
- Call/return: state=8, ns=111, cr=7'd40 -> state=40, ret_addr=9. Then ns=011 -> 41. Then ns=001 -> 9.

Source files
------------

// File: rtl/microsequencer.sv
// Next-state address logic and state register for the microprogrammed control unit.
// Selects the next microstate from ROM control fields, and counts MOC stall cycles for timeout.
module microsequencer #(
    parameter logic [6:0] RESET_STATE = 7'd0,
    parameter logic [6:0] FETCH_STATE = 7'd1,
    parameter logic [7:0] TIMEOUT     = 8'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] enc_state,
    input  logic [2:0] ns,
    input  logic [6:0] cr,
    input  logic       inv,
    input  logic [1:0] s,
    input  logic       moc,
    input  logic       cond,
    output logic [6:0] state,
    output logic [6:0] ret_addr,
    output logic       timeout
);

    localparam logic [2:0] NS_ENCODE      = 3'b000;
    localparam logic [2:0] NS_RETURN      = 3'b001;
    localparam logic [2:0] NS_JUMP        = 3'b010;
    localparam logic [2:0] NS_INC         = 3'b011;
    localparam logic [2:0] NS_COND_JUMP   = 3'b100;
    localparam logic [2:0] NS_COND_INC    = 3'b101;
    localparam logic [2:0] NS_COND_ENCODE = 3'b110;
    localparam logic [2:0] NS_CALL        = 3'b111;

    logic       sel_bit;
    logic       t;
    logic [6:0] inc;
    logic [6:0] next_state;
    logic [6:0] next_ret;
    logic       stall;
    logic [7:0] wait_cnt;
    logic [7:0] next_cnt;

    always_comb begin
        // NOTE: every combinational output is given a default first, so no latch is inferred.
        sel_bit = 1'b0;
        unique case (s)
            2'b00: sel_bit = moc;
            2'b01: sel_bit = cond;
            2'b10: sel_bit = 1'b1;
            2'b11: sel_bit = 1'b0;
        endcase
        t   = sel_bit ^ inv;
        inc = state + 7'd1;
    end

    always_comb begin
        next_state = state;
        next_ret   = ret_addr;
        unique case (ns)
            NS_ENCODE:      next_state = enc_state;
            NS_RETURN:      next_state = ret_addr;
            NS_JUMP:        next_state = cr;
            NS_INC:         next_state = inc;
            NS_COND_JUMP:   next_state = t ? cr : inc;
            NS_COND_INC:    next_state = t ? inc : state;
            NS_COND_ENCODE: next_state = t ? enc_state : FETCH_STATE;
            NS_CALL: begin
                next_state = cr;
                next_ret   = inc;
            end
        endcase
    end

    // A stall is a COND_INC whose condition fails; anything else restarts the count.
    always_comb begin
        stall    = (ns == NS_COND_INC) && !t;
        next_cnt = 8'd0;
        if (stall)
            next_cnt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            ret_addr <= 7'd0;
            wait_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state    <= next_state;
            ret_addr <= next_ret;
            wait_cnt <= next_cnt;
            if (stall && next_cnt == TIMEOUT)
                timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencing rules.
module tb_microsequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] enc_state;
    logic [2:0] ns;
    logic [6:0] cr;
    logic       inv;
    logic [1:0] s;
    logic       moc;
    logic       cond;
    logic [6:0] state;
    logic [6:0] ret_addr;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Behavioural model
    int m_state = 0;
    int m_ret   = 0;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    microsequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enc_state (enc_state),
        .ns        (ns),
        .cr        (cr),
        .inv       (inv),
        .s         (s),
        .moc       (moc),
        .cond      (cond),
        .state     (state),
        .ret_addr  (ret_addr),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic bit cond_true(input int sl, input bit i, input bit m, input bit cd);
        bit b;
        if (sl == 0)      b = m;
        else if (sl == 1) b = cd;
        else if (sl == 2) b = 1'b1;
        else              b = 1'b0;
        return b ^ i;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_ret   = 0;
        m_cnt   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge(input int n, input int c, input bit i, input int sl,
                                       input bit m, input bit cd, input int e);
        bit tt;
        int nxt;
        int plus1;
        tt    = cond_true(sl, i, m, cd);
        plus1 = (m_state + 1) % 128;
        nxt   = m_state;
        if (n == 0)      nxt = e;
        else if (n == 1) nxt = m_ret;
        else if (n == 2) nxt = c;
        else if (n == 3) nxt = plus1;
        else if (n == 4) nxt = tt ? c : plus1;
        else if (n == 5) nxt = tt ? plus1 : m_state;
        else if (n == 6) nxt = tt ? e : 1;
        else begin
            nxt   = c;
            m_ret = plus1;
        end
        if (n == 5 && !tt) begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_cnt == 32) m_to = 1'b1;
        end else begin
            m_cnt = 0;
        end
        m_state = nxt;
    endfunction

    // Drive one cycle of inputs, clock it, update the model, and settle past the edge.
    task automatic step(input logic [2:0] n, input logic [6:0] c, input logic i,
                        input logic [1:0] sl, input logic m, input logic cd,
                        input logic [6:0] e);
        ns = n; cr = c; inv = i; s = sl; moc = m; cond = cd; enc_state = e;
        @(posedge clk);
        model_edge(int'(n), int'(c), i, int'(sl), m, cd, int'(e));
        #1;
    endtask

    // Assert reset between edges, with no clock edge in the window.
    task automatic pulse_reset();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ns = 3'b011; cr = '0; inv = 1'b0; s = 2'b11; moc = 1'b0; cond = 1'b0; enc_state = '0;
        #3;
        total++;
        if (state !== 7'd0 || ret_addr !== 7'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_power_up: state=%0d ret=%0d timeout=%b want 0/0/0", state, ret_addr, timeout);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        step(3'b111, 7'd45, 0, 2'b11, 0, 0, 7'd0);
        total++;
        if (state !== 7'd45 || ret_addr !== 7'd1) begin
            bad++;
            $display("FAIL reset_setup_call: state=%0d ret=%0d want 45/1", state, ret_addr);
        end
        pulse_reset();
        total++;
        if (state !== 7'd0 || ret_addr !== 7'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: state=%0d ret=%0d timeout=%b want 0/0/0", state, ret_addr, timeout);
        end
        release_reset();
    endtask

    task automatic test_fetch_decode();
        step(3'b011, 7'd0, 0, 2'b11, 0, 0, 7'd0);
        total++;
        if (state !== 7'd1) begin
            bad++;
            $display("FAIL fetch_inc: state=%0d want 1", state);
        end
        step(3'b000, 7'd0, 0, 2'b11, 0, 0, 7'd10);
        total++;
        if (state !== 7'd10) begin
            bad++;
            $display("FAIL decode_encode: state=%0d want 10", state);
        end
        step(3'b010, 7'd127, 0, 2'b11, 0, 0, 7'd0);
        step(3'b011, 7'd0, 0, 2'b11, 0, 0, 7'd0);
        total++;
        if (state !== 7'd0) begin
            bad++;
            $display("FAIL inc_wrap: state=%0d want 0", state);
        end
    endtask

    task automatic test_cond_jump();
        step(3'b010, 7'd5, 0, 2'b11, 0, 0, 7'd0);
        step(3'b100, 7'd20, 0, 2'b00, 1, 0, 7'd0);
        total++;
        if (state !== 7'd20) begin
            bad++;
            $display("FAIL cjump_moc_taken: state=%0d want 20", state);
        end
        step(3'b010, 7'd5, 0, 2'b11, 0, 0, 7'd0);
        step(3'b100, 7'd20, 1, 2'b00, 1, 0, 7'd0);
        total++;
        if (state !== 7'd6) begin
            bad++;
            $display("FAIL cjump_inverted: state=%0d want 6", state);
        end
        step(3'b010, 7'd5, 0, 2'b11, 0, 0, 7'd0);
        step(3'b100, 7'd20, 0, 2'b10, 0, 0, 7'd0);
        total++;
        if (state !== 7'd20) begin
            bad++;
            $display("FAIL cjump_always: state=%0d want 20", state);
        end
        step(3'b010, 7'd5, 0, 2'b11, 0, 0, 7'd0);
        step(3'b100, 7'd20, 0, 2'b00, 0, 0, 7'd0);
        total++;
        if (state !== 7'd6) begin
            bad++;
            $display("FAIL cjump_moc_low: state=%0d want 6", state);
        end
    endtask

    task automatic test_memory_wait();
        pulse_reset();
        release_reset();
        step(3'b010, 7'd50, 0, 2'b11, 0, 0, 7'd0);
        // A broken stall run must restart the count.
        for (int k = 0; k < 20; k++) step(3'b101, 7'd0, 0, 2'b00, 0, 0, 7'd0);
        step(3'b101, 7'd0, 0, 2'b00, 1, 0, 7'd0);
        for (int k = 0; k < 20; k++) step(3'b101, 7'd0, 0, 2'b00, 0, 0, 7'd0);
        total++;
        if (state !== 7'd51 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL wait_count_clears: state=%0d timeout=%b want 51/0", state, timeout);
        end
        step(3'b101, 7'd0, 0, 2'b00, 1, 0, 7'd0);
        for (int k = 0; k < 31; k++) step(3'b101, 7'd0, 0, 2'b00, 0, 0, 7'd0);
        total++;
        if (state !== 7'd52 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL wait_31_stalls: state=%0d timeout=%b want 52/0", state, timeout);
        end
        step(3'b101, 7'd0, 0, 2'b00, 0, 0, 7'd0);
        total++;
        if (state !== 7'd52 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL wait_32nd_stall: state=%0d timeout=%b want 52/1", state, timeout);
        end
        step(3'b101, 7'd0, 0, 2'b00, 1, 0, 7'd0);
        total++;
        if (state !== 7'd53 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL wait_release_sticky: state=%0d timeout=%b want 53/1", state, timeout);
        end
    endtask

    task automatic test_cond_skip();
        step(3'b110, 7'd0, 0, 2'b01, 0, 0, 7'd12);
        total++;
        if (state !== 7'd1) begin
            bad++;
            $display("FAIL skip_fetch: state=%0d want 1", state);
        end
        step(3'b110, 7'd0, 0, 2'b01, 0, 1, 7'd12);
        total++;
        if (state !== 7'd12) begin
            bad++;
            $display("FAIL skip_encode: state=%0d want 12", state);
        end
    endtask

    task automatic test_call_return();
        step(3'b010, 7'd8, 0, 2'b11, 0, 0, 7'd0);
        step(3'b111, 7'd40, 0, 2'b11, 0, 0, 7'd0);
        total++;
        if (state !== 7'd40 || ret_addr !== 7'd9) begin
            bad++;
            $display("FAIL call: state=%0d ret=%0d want 40/9", state, ret_addr);
        end
        step(3'b011, 7'd0, 0, 2'b11, 0, 0, 7'd0);
        total++;
        if (state !== 7'd41 || ret_addr !== 7'd9) begin
            bad++;
            $display("FAIL call_body: state=%0d ret=%0d want 41/9", state, ret_addr);
        end
        step(3'b001, 7'd0, 0, 2'b11, 0, 0, 7'd0);
        total++;
        if (state !== 7'd9) begin
            bad++;
            $display("FAIL return: state=%0d want 9", state);
        end
        // CALL from the return target replaces the single-level return address.
        step(3'b111, 7'd70, 0, 2'b11, 0, 0, 7'd0);
        total++;
        if (state !== 7'd70 || ret_addr !== 7'd10) begin
            bad++;
            $display("FAIL call_overwrite: state=%0d ret=%0d want 70/10", state, ret_addr);
        end
    endtask

    task automatic test_random();
        logic [2:0] n;
        logic [1:0] sl;
        for (int k = 0; k < 600; k++) begin
            if (k % 150 == 149) begin
                pulse_reset();
                total++;
                if (state !== 7'd0 || ret_addr !== 7'd0 || timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_reset[%0d]: state=%0d ret=%0d timeout=%b want 0/0/0", k, state, ret_addr, timeout);
                end
                release_reset();
            end
            n  = 3'($urandom_range(0, 7));
            sl = 2'($urandom_range(0, 3));
            // Long stall bursts so the timeout threshold is reached under random traffic.
            if ((k % 150) >= 40 && (k % 150) < 80) begin
                n  = 3'b101;
                sl = 2'b11;
            end
            step(n, 7'($urandom), 1'($urandom) & 1'((k % 150) < 40 || (k % 150) >= 80),
                 sl, 1'($urandom), 1'($urandom), 7'($urandom));
            total++;
            if (int'(state) != m_state || int'(ret_addr) != m_ret || timeout !== m_to) begin
                bad++;
                $display("FAIL rand[%0d]: state=%0d ret=%0d timeout=%b want %0d/%0d/%b",
                         k, state, ret_addr, timeout, m_state, m_ret, m_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_decode();
        test_cond_jump();
        test_memory_wait();
        test_cond_skip();
        test_call_return();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
